axi_mem_slave: RTL and testbench
================================

# axi_mem_slave

AXI4 memory responder: the target end of the AXI master bus driven by the processor's cache-side AXI controller. Accepts one write burst and one read burst concurrently, stores data in an internal word array, and returns B and R responses. Used as the simulation and FPGA main memory behind the core's 512-bit cache-line refills and write-backs (8 beats × 64 bits).

## Interface
- AXI_DATA_WIDTH, 64, data bus width; only 64 is supported.
- AXI_ADDR_WIDTH, 64, address width.
- AXI_ID_WIDTH, 4, ID width.
- AXI_USER_WIDTH, 1, user sideband width.
- MEM_DEPTH, 1024, number of 64-bit words; must be a power of 2.
- MEM_BASE, 64'h8000_0000, byte address of word 0.

Ports:
- clk  in  1  clock; all logic rises on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- axi_aw_valid / axi_aw_ready  in / out  1  write-address handshake.
- axi_aw_addr, axi_aw_id, axi_aw_len, axi_aw_size, axi_aw_burst  in  ADDR/ID/8/3/2  write-address payload.
- axi_aw_prot/lock/cache/qos/region/user  in  various  accepted and ignored.
- axi_w_valid / axi_w_ready  in / out  1  write-data handshake.
- axi_w_data, axi_w_strb  in  64/8  write data and byte enables.
- axi_w_last, axi_w_user  in  1/USER  ignored.
- axi_b_valid / axi_b_ready  out / in  1  write-response handshake.
- axi_b_resp, axi_b_id, axi_b_user  out  2/ID/USER  response, echoed ID, and user (0).
- axi_ar_valid / axi_ar_ready  in / out  1  read-address handshake.
- axi_ar_addr, axi_ar_id, axi_ar_len, axi_ar_size, axi_ar_burst  in  ADDR/ID/8/3/2  read-address payload.
- axi_ar_prot/lock/cache/qos/region/user  in  various  ignored.
- axi_r_valid / axi_r_ready  out / in  1  read-data handshake.
- axi_r_data, axi_r_resp, axi_r_last, axi_r_id, axi_r_user  out  64/2/1/ID/USER  read beat.

## Operation
- Write FSM states are W_IDLE, W_DATA and W_RESP.
  - axi_aw_ready is 1 only in W_IDLE.
  - On the AW handshake the block latches addr, len, size, burst and id, clears the beat counter, and moves to W_DATA.
  - In W_DATA axi_w_ready is 1. Each W handshake writes the bytes enabled by axi_w_strb into mem[idx], then advances the address and increments the beat counter.
  - The handshake with beat counter == len moves the FSM to W_RESP. axi_w_last is not checked.
  - In W_RESP axi_b_valid is 1 until axi_b_ready, then the FSM returns to W_IDLE.
- Read FSM states are R_IDLE and R_DATA.
  - axi_ar_ready is 1 only in R_IDLE.
  - On the AR handshake the block latches the payload, loads axi_r_data from mem[idx], and moves to R_DATA.
  - In R_DATA axi_r_valid is 1, and axi_r_last = (beat counter == len).
  - A handshake that is not the last beat advances the address and loads the next word into axi_r_data.
  - A handshake on the last beat returns the FSM to R_IDLE.
- Word index: idx = ((addr − MEM_BASE) >> 3) mod MEM_DEPTH.
- Next address:
  - FIXED: unchanged.
  - INCR: addr + (1 << size).
  - WRAP: treated as INCR.
  - Reserved (2'b11): treated as INCR.
- Sub-word sizes index by the full address, so beats within one word hit the same idx.
- Read/write collision: a write commits at the end of its handshake cycle. A read load in the same cycle to the same idx returns the old word.
- The read and write FSMs are fully independent; there is no arbitration.

## Timing
- Reset values: axi_b_valid=0, axi_r_valid=0, axi_r_last=0, axi_r_data=0, axi_b_resp=0, axi_r_resp=0, ids=0, user=0.
- Both FSMs reset to their idle state, so axi_aw_ready=axi_ar_ready=1 and axi_w_ready=0.
- Memory contents are not reset.
- All ready signals are decoded combinationally from state. All valid and payload outputs are registered.
- AR handshake at cycle T gives beat 0 valid in cycle T+1. With axi_r_ready held at 1, an 8-beat burst finishes at T+8, and the next AR is accepted at T+9.
- AW handshake at T allows the first W handshake at T+1. The last W handshake at cycle L gives axi_b_valid at L+1.
- axi_r_valid and axi_b_valid, once asserted, stay asserted with a stable payload until their handshake.
- Reset asserted mid-burst aborts the burst immediately. No response is sent; writes from beats already completed persist.

## Configuration
- AXI_MEM_DECERR_EN defined: the range check is enabled.
  - An address outside [MEM_BASE, MEM_BASE + 8·MEM_DEPTH) is checked per beat.
  - Out-of-range write beats are dropped, and axi_b_resp = 2'b11 (DECERR) if any beat was out of range.
  - Out-of-range read beats return data 0 with axi_r_resp = 2'b11.
- AXI_MEM_DECERR_EN undefined: no range check. Addresses wrap modulo MEM_DEPTH and all responses are OKAY (2'b00).

## Structure
- Package axi_pkg holds:
  - burst codes: FIXED 2'b00, INCR 2'b01, WRAP 2'b10.
  - response codes: OKAY 2'b00, SLVERR 2'b10, DECERR 2'b11.
  - FSM state encodings.
- Sub-module axi_burst_addr: a combinational next-address and index calculator (addr, size, burst → next_addr, idx, in_range), instantiated once for the read channel and once for the write channel.

## Test plan
- Single write then read: write 64'hDEAD_BEEF_0123_4567 at 0x8000_0010, len=0, strb=8'hFF, then read it back → r_data matches, r_last=1, r_resp=0, r_id echoes the AR id.
- 8-beat INCR write at 0x8000_0040 (data i·0x11), then 8-beat read with r_ready held at 1 → beats 0..7 in order, r_last only on beat 7, 8 consecutive valid cycles.
- Partial strobe: word preloaded with all ones, write 64'h0 with strb=8'h0F → read returns 64'hFFFF_FFFF_0000_0000.
- Backpressure: r_ready toggles 1,0,0,1 → r_data and r_last are held stable while stalled; no beat is lost or duplicated. b_ready delayed 5 cycles → b_valid held high for 5 cycles.
- Concurrent: AR and AW handshake in the same cycle to the same address → the read returns the old word; a subsequent read returns the new word.
- With AXI_MEM_DECERR_EN defined, write and read at 0x7000_0000 → b_resp=2'b11 and r_resp=2'b11 with r_data=0. Without the macro → OKAY, and the access aliases to word ((0x7000_0000−MEM_BASE)>>3) mod MEM_DEPTH.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI encodings and FSM state types for the memory responder.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational burst address step plus word index and range decode for the
// internal 64-bit word array.
module axi_burst_addr #(
    parameter int                ADDR_W    = 64,
    parameter int                MEM_DEPTH = 1024,
    parameter logic [ADDR_W-1:0] MEM_BASE  = 'h8000_0000,
    localparam int               IDX_W     = $clog2(MEM_DEPTH)
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [2:0]        i_size,
    input  logic [1:0]        i_burst,
    output logic [ADDR_W-1:0] o_next_addr,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_in_range
);
    import axi_pkg::*;

    logic [ADDR_W-1:0] w_off;

    assign w_off = i_addr - MEM_BASE;
    // Word index wraps modulo MEM_DEPTH; sub-word beats share a word.
    assign o_idx       = w_off[IDX_W+2:3];
    assign o_in_range  = (i_addr >= MEM_BASE) && ((w_off >> (IDX_W + 3)) == '0);
    // WRAP and the reserved code both step like INCR.
    assign o_next_addr = (i_burst == BURST_FIXED) ? i_addr
                                                  : i_addr + (ADDR_W'(1) << i_size);

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 memory responder: one write and one read burst in flight, word array storage.
// Define AXI_MEM_DECERR_EN to drop/zero out-of-range beats and answer DECERR.
module axi_mem_slave
    import axi_pkg::*;
#(
    parameter int                        AXI_DATA_WIDTH = 64,
    parameter int                        AXI_ADDR_WIDTH = 64,
    parameter int                        AXI_ID_WIDTH   = 4,
    parameter int                        AXI_USER_WIDTH = 1,
    parameter int                        MEM_DEPTH      = 1024,
    parameter logic [AXI_ADDR_WIDTH-1:0] MEM_BASE       = 'h8000_0000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        axi_aw_valid,
    output logic                        axi_aw_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr,
    input  logic [AXI_ID_WIDTH-1:0]     axi_aw_id,
    input  logic [7:0]                  axi_aw_len,
    input  logic [2:0]                  axi_aw_size,
    input  logic [1:0]                  axi_aw_burst,
    input  logic [2:0]                  axi_aw_prot,
    input  logic                        axi_aw_lock,
    input  logic [3:0]                  axi_aw_cache,
    input  logic [3:0]                  axi_aw_qos,
    input  logic [3:0]                  axi_aw_region,
    input  logic [AXI_USER_WIDTH-1:0]   axi_aw_user,
    input  logic                        axi_w_valid,
    output logic                        axi_w_ready,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_w_data,
    input  logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb,
    input  logic                        axi_w_last,
    input  logic [AXI_USER_WIDTH-1:0]   axi_w_user,
    output logic                        axi_b_valid,
    input  logic                        axi_b_ready,
    output logic [1:0]                  axi_b_resp,
    output logic [AXI_ID_WIDTH-1:0]     axi_b_id,
    output logic [AXI_USER_WIDTH-1:0]   axi_b_user,
    input  logic                        axi_ar_valid,
    output logic                        axi_ar_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_ar_addr,
    input  logic [AXI_ID_WIDTH-1:0]     axi_ar_id,
    input  logic [7:0]                  axi_ar_len,
    input  logic [2:0]                  axi_ar_size,
    input  logic [1:0]                  axi_ar_burst,
    input  logic [2:0]                  axi_ar_prot,
    input  logic                        axi_ar_lock,
    input  logic [3:0]                  axi_ar_cache,
    input  logic [3:0]                  axi_ar_qos,
    input  logic [3:0]                  axi_ar_region,
    input  logic [AXI_USER_WIDTH-1:0]   axi_ar_user,
    output logic                        axi_r_valid,
    input  logic                        axi_r_ready,
    output logic [AXI_DATA_WIDTH-1:0]   axi_r_data,
    output logic [1:0]                  axi_r_resp,
    output logic                        axi_r_last,
    output logic [AXI_ID_WIDTH-1:0]     axi_r_id,
    output logic [AXI_USER_WIDTH-1:0]   axi_r_user
);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int STRB_W = AXI_DATA_WIDTH / 8;
`ifdef AXI_MEM_DECERR_EN
    localparam logic RANGE_CHK = 1'b1;
`else
    localparam logic RANGE_CHK = 1'b0;
`endif

    logic [AXI_DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    wstate_t r_wstate, w_wstate_nxt;
    rstate_t r_rstate, w_rstate_nxt;

    logic [AXI_ADDR_WIDTH-1:0] r_waddr, r_raddr;
    logic [7:0]                r_wlen, r_wcnt, r_rlen, r_rcnt;
    logic [2:0]                r_wsize, r_rsize;
    logic [1:0]                r_wburst, r_rburst;
    logic                      r_werr;
    logic                      r_bvalid, r_rvalid, r_rlast;
    logic [1:0]                r_bresp, r_rresp;
    logic [AXI_ID_WIDTH-1:0]   r_bid, r_rid;
    logic [AXI_DATA_WIDTH-1:0] r_rdata;

    logic                      w_aw_hs, w_w_hs, w_w_last, w_b_hs, w_ar_hs, w_r_hs;
    logic [AXI_ADDR_WIDTH-1:0] w_wnext, w_rnext, w_rsel_addr;
    logic [IDX_W-1:0]          w_widx, w_ridx;
    logic                      w_win, w_rin, w_wbeat_ok, w_rbeat_ok;
    logic [2:0]                w_rsel_size;
    logic [1:0]                w_rsel_burst;
    logic [AXI_DATA_WIDTH-1:0] w_rload_data;
    logic [1:0]                w_rload_resp;
    logic                      w_unused;

    assign w_unused = ^{axi_aw_prot, axi_aw_lock, axi_aw_cache, axi_aw_qos, axi_aw_region,
                        axi_aw_user, axi_w_last, axi_w_user, axi_ar_prot, axi_ar_lock,
                        axi_ar_cache, axi_ar_qos, axi_ar_region, axi_ar_user};

    assign w_aw_hs  = axi_aw_valid && (r_wstate == W_IDLE);
    assign w_w_hs   = axi_w_valid && (r_wstate == W_DATA);
    assign w_w_last = w_w_hs && (r_wcnt == r_wlen);
    assign w_b_hs   = r_bvalid && axi_b_ready;
    assign w_ar_hs  = axi_ar_valid && (r_rstate == R_IDLE);
    assign w_r_hs   = r_rvalid && axi_r_ready;

    axi_burst_addr #(.ADDR_W(AXI_ADDR_WIDTH), .MEM_DEPTH(MEM_DEPTH), .MEM_BASE(MEM_BASE)) u_waddr (
        .i_addr(r_waddr), .i_size(r_wsize), .i_burst(r_wburst),
        .o_next_addr(w_wnext), .o_idx(w_widx), .o_in_range(w_win)
    );

    // While idle the read calculator looks at the incoming AR so beat 0 loads on the handshake.
    assign w_rsel_addr  = (r_rstate == R_IDLE) ? axi_ar_addr  : r_raddr;
    assign w_rsel_size  = (r_rstate == R_IDLE) ? axi_ar_size  : r_rsize;
    assign w_rsel_burst = (r_rstate == R_IDLE) ? axi_ar_burst : r_rburst;

    axi_burst_addr #(.ADDR_W(AXI_ADDR_WIDTH), .MEM_DEPTH(MEM_DEPTH), .MEM_BASE(MEM_BASE)) u_raddr (
        .i_addr(w_rsel_addr), .i_size(w_rsel_size), .i_burst(w_rsel_burst),
        .o_next_addr(w_rnext), .o_idx(w_ridx), .o_in_range(w_rin)
    );

    assign w_wbeat_ok   = !RANGE_CHK || w_win;
    assign w_rbeat_ok   = !RANGE_CHK || w_rin;
    assign w_rload_data = w_rbeat_ok ? r_mem[w_ridx] : '0;
    assign w_rload_resp = w_rbeat_ok ? RESP_OKAY : RESP_DECERR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        axi_aw_ready = 1'b0;
        axi_w_ready  = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                axi_aw_ready = 1'b1;
                if (axi_aw_valid) w_wstate_nxt = W_DATA;
            end
            W_DATA: begin
                axi_w_ready = 1'b1;
                if (axi_w_valid && (r_wcnt == r_wlen)) w_wstate_nxt = W_RESP;
            end
            W_RESP: if (axi_b_ready) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        axi_ar_ready = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                axi_ar_ready = 1'b1;
                if (axi_ar_valid) w_rstate_nxt = R_DATA;
            end
            R_DATA: if (axi_r_ready && (r_rcnt == r_rlen)) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_waddr  <= '0;
            r_wlen   <= '0;
            r_wcnt   <= '0;
            r_wsize  <= '0;
            r_wburst <= '0;
            r_werr   <= 1'b0;
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
            r_bid    <= '0;
        end else begin
            if (w_aw_hs) begin
                r_waddr  <= axi_aw_addr;
                r_wlen   <= axi_aw_len;
                r_wsize  <= axi_aw_size;
                r_wburst <= axi_aw_burst;
                r_wcnt   <= '0;
                r_werr   <= 1'b0;
                r_bid    <= axi_aw_id;
            end
            if (w_w_hs) begin
                r_waddr <= w_wnext;
                r_wcnt  <= r_wcnt + 8'd1;
                if (!w_wbeat_ok) r_werr <= 1'b1;
            end
            if (w_w_last) begin
                r_bvalid <= 1'b1;
                r_bresp  <= (r_werr || !w_wbeat_ok) ? RESP_DECERR : RESP_OKAY;
            end else if (w_b_hs) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Array is not reset; a same-cycle read load sees the pre-write word.
    always_ff @(posedge clk) begin
        if (w_w_hs && w_wbeat_ok) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (axi_w_strb[b]) r_mem[w_widx][8*b +: 8] <= axi_w_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raddr  <= '0;
            r_rlen   <= '0;
            r_rcnt   <= '0;
            r_rsize  <= '0;
            r_rburst <= '0;
            r_rid    <= '0;
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_raddr  <= w_rnext;
            r_rlen   <= axi_ar_len;
            r_rsize  <= axi_ar_size;
            r_rburst <= axi_ar_burst;
            r_rcnt   <= '0;
            r_rid    <= axi_ar_id;
            r_rvalid <= 1'b1;
            r_rlast  <= (axi_ar_len == 8'd0);
            r_rdata  <= w_rload_data;
            r_rresp  <= w_rload_resp;
        end else if (w_r_hs) begin
            if (r_rcnt == r_rlen) begin
                r_rvalid <= 1'b0;
                r_rlast  <= 1'b0;
            end else begin
                r_raddr <= w_rnext;
                r_rcnt  <= r_rcnt + 8'd1;
                r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
                r_rdata <= w_rload_data;
                r_rresp <= w_rload_resp;
            end
        end
    end

    assign axi_b_valid = r_bvalid;
    assign axi_b_resp  = r_bresp;
    assign axi_b_id    = r_bid;
    assign axi_b_user  = '0;
    assign axi_r_valid = r_rvalid;
    assign axi_r_data  = r_rdata;
    assign axi_r_resp  = r_rresp;
    assign axi_r_last  = r_rlast;
    assign axi_r_id    = r_rid;
    assign axi_r_user  = '0;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave (default build, range check disabled).
module tb_axi_mem_slave;
    import axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        axi_aw_valid, axi_aw_ready, axi_aw_lock;
    logic [63:0] axi_aw_addr;
    logic [3:0]  axi_aw_id, axi_aw_cache, axi_aw_qos, axi_aw_region;
    logic [7:0]  axi_aw_len;
    logic [2:0]  axi_aw_size, axi_aw_prot;
    logic [1:0]  axi_aw_burst;
    logic [0:0]  axi_aw_user;
    logic        axi_w_valid, axi_w_ready, axi_w_last;
    logic [63:0] axi_w_data;
    logic [7:0]  axi_w_strb;
    logic [0:0]  axi_w_user;
    logic        axi_b_valid, axi_b_ready;
    logic [1:0]  axi_b_resp;
    logic [3:0]  axi_b_id;
    logic [0:0]  axi_b_user;
    logic        axi_ar_valid, axi_ar_ready, axi_ar_lock;
    logic [63:0] axi_ar_addr;
    logic [3:0]  axi_ar_id, axi_ar_cache, axi_ar_qos, axi_ar_region;
    logic [7:0]  axi_ar_len;
    logic [2:0]  axi_ar_size, axi_ar_prot;
    logic [1:0]  axi_ar_burst;
    logic [0:0]  axi_ar_user;
    logic        axi_r_valid, axi_r_ready, axi_r_last;
    logic [63:0] axi_r_data;
    logic [1:0]  axi_r_resp;
    logic [3:0]  axi_r_id;
    logic [0:0]  axi_r_user;

    axi_mem_slave dut (
        .clk(clk), .rst_n(rst_n),
        .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready), .axi_aw_addr(axi_aw_addr),
        .axi_aw_id(axi_aw_id), .axi_aw_len(axi_aw_len), .axi_aw_size(axi_aw_size),
        .axi_aw_burst(axi_aw_burst), .axi_aw_prot(axi_aw_prot), .axi_aw_lock(axi_aw_lock),
        .axi_aw_cache(axi_aw_cache), .axi_aw_qos(axi_aw_qos), .axi_aw_region(axi_aw_region),
        .axi_aw_user(axi_aw_user),
        .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready), .axi_w_data(axi_w_data),
        .axi_w_strb(axi_w_strb), .axi_w_last(axi_w_last), .axi_w_user(axi_w_user),
        .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready), .axi_b_resp(axi_b_resp),
        .axi_b_id(axi_b_id), .axi_b_user(axi_b_user),
        .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready), .axi_ar_addr(axi_ar_addr),
        .axi_ar_id(axi_ar_id), .axi_ar_len(axi_ar_len), .axi_ar_size(axi_ar_size),
        .axi_ar_burst(axi_ar_burst), .axi_ar_prot(axi_ar_prot), .axi_ar_lock(axi_ar_lock),
        .axi_ar_cache(axi_ar_cache), .axi_ar_qos(axi_ar_qos), .axi_ar_region(axi_ar_region),
        .axi_ar_user(axi_ar_user),
        .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready), .axi_r_data(axi_r_data),
        .axi_r_resp(axi_r_resp), .axi_r_last(axi_r_last), .axi_r_id(axi_r_id),
        .axi_r_user(axi_r_user)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [3:0] id, input logic [63:0] d0, input logic [63:0] dstep,
                            input logic [7:0] strb, input int hold,
                            output logic [1:0] resp, output logic [3:0] bid, output int held);
        int n;
        axi_aw_valid = 1'b1; axi_aw_addr = addr; axi_aw_len = len; axi_aw_size = 3'd3;
        axi_aw_burst = burst; axi_aw_id = id;
        n = 0;
        while (!axi_aw_ready && n < 50) begin step(); n++; end
        if (n >= 50) chk("aw_timeout", 64'(n), 64'd0);
        step();
        axi_aw_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            axi_w_valid = 1'b1; axi_w_data = d0 + 64'(i) * dstep; axi_w_strb = strb;
            axi_w_last = (i == int'(len));
            n = 0;
            while (!axi_w_ready && n < 50) begin step(); n++; end
            if (n >= 50) chk("w_timeout", 64'(n), 64'd0);
            step();
        end
        axi_w_valid = 1'b0; axi_w_last = 1'b0;
        n = 0;
        while (!axi_b_valid && n < 50) begin step(); n++; end
        if (n >= 50) chk("b_timeout", 64'(n), 64'd0);
        held = 0;
        for (int i = 0; i < hold; i++) begin
            if (axi_b_valid) held++;
            step();
        end
        resp = axi_b_resp; bid = axi_b_id;
        axi_b_ready = 1'b1;
        step();
        axi_b_ready = 1'b0;
    endtask

    logic [63:0] rd_data [16];
    logic        rd_last [16];
    logic [1:0]  rd_resp [16];
    logic [3:0]  rd_id;
    int          rd_n, rd_cycles, rd_unstable, rd_gaps;

    task automatic do_read(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [3:0] id, input logic [15:0] rpat);
        int n, cyc;
        bit stalled;
        logic [63:0] pd;
        logic pl;
        axi_ar_valid = 1'b1; axi_ar_addr = addr; axi_ar_len = len; axi_ar_size = 3'd3;
        axi_ar_burst = burst; axi_ar_id = id;
        n = 0;
        while (!axi_ar_ready && n < 50) begin step(); n++; end
        if (n >= 50) chk("ar_timeout", 64'(n), 64'd0);
        step();
        axi_ar_valid = 1'b0;
        rd_n = 0; cyc = 0; rd_unstable = 0; rd_gaps = 0; stalled = 1'b0; pd = '0; pl = 1'b0;
        while (rd_n <= int'(len) && cyc < 100) begin
            axi_r_ready = rpat[cyc[3:0]];
            if (!axi_r_valid) begin
                rd_gaps++;
            end else begin
                if (stalled && (axi_r_data !== pd || axi_r_last !== pl)) rd_unstable++;
                pd = axi_r_data; pl = axi_r_last;
                if (axi_r_ready) begin
                    rd_data[rd_n] = axi_r_data; rd_last[rd_n] = axi_r_last;
                    rd_resp[rd_n] = axi_r_resp; rd_id = axi_r_id;
                    rd_n++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                end
            end
            step();
            cyc++;
        end
        axi_r_ready = 1'b0;
        rd_cycles = cyc;
    endtask

    typedef struct {
        bit          do_wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  strb;
        logic [3:0]  id;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [1:0] resp;
        logic [3:0] bid, rid_exp;
        int held;

        vecs[0] = '{1'b1, 64'h8000_0010, 64'hDEAD_BEEF_0123_4567, 8'hFF, 4'h3, 64'hDEAD_BEEF_0123_4567};
        vecs[1] = '{1'b1, 64'h8000_0018, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 4'h7, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[2] = '{1'b1, 64'h8000_0018, 64'h0,                   8'h0F, 4'h9, 64'hFFFF_FFFF_0000_0000};
        vecs[3] = '{1'b1, 64'h8000_0018, 64'h0,                   8'h81, 4'hF, 64'h00FF_FFFF_0000_0000};
        vecs[4] = '{1'b1, 64'h7000_0000, 64'h1122_3344_5566_7788, 8'hFF, 4'h1, 64'h1122_3344_5566_7788};
        vecs[5] = '{1'b0, 64'h8000_0000, 64'h0,                   8'h00, 4'h2, 64'h1122_3344_5566_7788};
        vecs[6] = '{1'b1, 64'h8000_2000, 64'hA5A5_5A5A_C3C3_3C3C, 8'hFF, 4'h4, 64'hA5A5_5A5A_C3C3_3C3C};
        vecs[7] = '{1'b0, 64'h8000_0000, 64'h0,                   8'h00, 4'h6, 64'hA5A5_5A5A_C3C3_3C3C};

        axi_aw_valid = 0; axi_aw_addr = 0; axi_aw_id = 0; axi_aw_len = 0; axi_aw_size = 3;
        axi_aw_burst = BURST_INCR; axi_aw_prot = 0; axi_aw_lock = 0; axi_aw_cache = 0;
        axi_aw_qos = 0; axi_aw_region = 0; axi_aw_user = 0;
        axi_w_valid = 0; axi_w_data = 0; axi_w_strb = 0; axi_w_last = 0; axi_w_user = 0;
        axi_b_ready = 0;
        axi_ar_valid = 0; axi_ar_addr = 0; axi_ar_id = 0; axi_ar_len = 0; axi_ar_size = 3;
        axi_ar_burst = BURST_INCR; axi_ar_prot = 0; axi_ar_lock = 0; axi_ar_cache = 0;
        axi_ar_qos = 0; axi_ar_region = 0; axi_ar_user = 0;
        axi_r_ready = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_aw_ready", 64'(axi_aw_ready), 64'd1);
        chk("rst_ar_ready", 64'(axi_ar_ready), 64'd1);
        chk("rst_w_ready",  64'(axi_w_ready),  64'd0);
        chk("rst_b_valid",  64'(axi_b_valid),  64'd0);
        chk("rst_r_valid",  64'(axi_r_valid),  64'd0);
        chk("rst_r_last",   64'(axi_r_last),   64'd0);
        chk("rst_r_data",   axi_r_data,        64'd0);
        chk("rst_b_resp",   64'(axi_b_resp),   64'd0);
        chk("rst_r_resp",   64'(axi_r_resp),   64'd0);
        chk("rst_ids",      64'({axi_b_id, axi_r_id}), 64'd0);
        chk("rst_user",     64'({axi_b_user, axi_r_user}), 64'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].do_wr) begin
                do_write(vecs[i].addr, 8'd0, BURST_INCR, vecs[i].id, vecs[i].wdata, 64'd0,
                         vecs[i].strb, 0, resp, bid, held);
                chk($sformatf("v%0d_b_resp", i), 64'(resp), 64'(RESP_OKAY));
                chk($sformatf("v%0d_b_id", i), 64'(bid), 64'(vecs[i].id));
            end
            rid_exp = vecs[i].id + 4'd1;
            do_read(vecs[i].addr, 8'd0, BURST_INCR, rid_exp, 16'hFFFF);
            chk($sformatf("v%0d_beats", i), 64'(rd_n), 64'd1);
            chk($sformatf("v%0d_r_data", i), rd_data[0], vecs[i].exp);
            chk($sformatf("v%0d_r_last", i), 64'(rd_last[0]), 64'd1);
            chk($sformatf("v%0d_r_resp", i), 64'(rd_resp[0]), 64'(RESP_OKAY));
            chk($sformatf("v%0d_r_id", i), 64'(rd_id), 64'(rid_exp));
        end

        // 8-beat cache line, read back with r_ready held high.
        do_write(64'h8000_0040, 8'd7, BURST_INCR, 4'h5, 64'h0, 64'h11, 8'hFF, 0, resp, bid, held);
        chk("burst_b_resp", 64'(resp), 64'(RESP_OKAY));
        chk("burst_b_id", 64'(bid), 64'h5);
        do_read(64'h8000_0040, 8'd7, BURST_INCR, 4'hA, 16'hFFFF);
        chk("burst_beats", 64'(rd_n), 64'd8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("burst_data%0d", k), rd_data[k], 64'(k) * 64'h11);
            chk($sformatf("burst_last%0d", k), 64'(rd_last[k]), 64'(k == 7));
        end
        chk("burst_cycles", 64'(rd_cycles), 64'd8);
        chk("burst_gaps", 64'(rd_gaps), 64'd0);
        chk("burst_r_id", 64'(rd_id), 64'hA);
        chk("burst_ar_ready_after", 64'(axi_ar_ready), 64'd1);

        // r_ready pattern 1,0,0,1 repeating.
        do_read(64'h8000_0040, 8'd3, BURST_INCR, 4'h2, 16'h9999);
        chk("bp_beats", 64'(rd_n), 64'd4);
        chk("bp_cycles", 64'(rd_cycles), 64'd8);
        chk("bp_unstable", 64'(rd_unstable), 64'd0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp_data%0d", k), rd_data[k], 64'(k) * 64'h11);
            chk($sformatf("bp_last%0d", k), 64'(rd_last[k]), 64'(k == 3));
        end

        do_write(64'h8000_0080, 8'd0, BURST_INCR, 4'hC, 64'h5555, 64'd0, 8'hFF, 5, resp, bid, held);
        chk("bdelay_held", 64'(held), 64'd5);
        chk("bdelay_b_id", 64'(bid), 64'hC);
        chk("bdelay_b_valid_after", 64'(axi_b_valid), 64'd0);

        // FIXED burst keeps hitting one word; reserved burst code steps like INCR.
        do_write(64'h8000_0200, 8'd1, BURST_FIXED, 4'h1, 64'h1000, 64'h1, 8'hFF, 0, resp, bid, held);
        do_read(64'h8000_0200, 8'd1, BURST_FIXED, 4'h1, 16'hFFFF);
        chk("fixed_d0", rd_data[0], 64'h1001);
        chk("fixed_d1", rd_data[1], 64'h1001);
        do_read(64'h8000_0040, 8'd1, 2'b11, 4'h1, 16'hFFFF);
        chk("rsvd_d0", rd_data[0], 64'h0);
        chk("rsvd_d1", rd_data[1], 64'h11);

        // AR handshake in the same cycle as the W beat to the same word.
        do_write(64'h8000_0100, 8'd0, BURST_INCR, 4'h3, 64'h0123_4567_89AB_CDEF, 64'd0, 8'hFF, 0,
                 resp, bid, held);
        axi_aw_valid = 1'b1; axi_aw_addr = 64'h8000_0100; axi_aw_len = 8'd0; axi_aw_id = 4'h3;
        axi_aw_burst = BURST_INCR;
        step();
        axi_aw_valid = 1'b0;
        axi_w_valid = 1'b1; axi_w_data = 64'hFEDC_BA98_7654_3210; axi_w_strb = 8'hFF; axi_w_last = 1'b1;
        axi_ar_valid = 1'b1; axi_ar_addr = 64'h8000_0100; axi_ar_len = 8'd0; axi_ar_id = 4'h8;
        axi_ar_burst = BURST_INCR;
        chk("coll_both_ready", 64'({axi_w_ready, axi_ar_ready}), 64'h3);
        step();
        axi_w_valid = 1'b0; axi_w_last = 1'b0; axi_ar_valid = 1'b0;
        chk("coll_r_valid", 64'(axi_r_valid), 64'd1);
        chk("coll_old_word", axi_r_data, 64'h0123_4567_89AB_CDEF);
        chk("coll_b_valid", 64'(axi_b_valid), 64'd1);
        axi_r_ready = 1'b1; axi_b_ready = 1'b1;
        step();
        axi_r_ready = 1'b0; axi_b_ready = 1'b0;
        do_read(64'h8000_0100, 8'd0, BURST_INCR, 4'h8, 16'hFFFF);
        chk("coll_new_word", rd_data[0], 64'hFEDC_BA98_7654_3210);

        // Reset during a write burst: completed beats stay, no response appears.
        do_write(64'h8000_0300, 8'd3, BURST_INCR, 4'h0, 64'hF0, 64'h1, 8'hFF, 0, resp, bid, held);
        axi_aw_valid = 1'b1; axi_aw_addr = 64'h8000_0300; axi_aw_len = 8'd3; axi_aw_id = 4'h6;
        step();
        axi_aw_valid = 1'b0;
        axi_w_valid = 1'b1; axi_w_strb = 8'hFF; axi_w_data = 64'hA0;
        step();
        axi_w_data = 64'hA1;
        step();
        axi_w_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_w_ready", 64'(axi_w_ready), 64'd0);
        chk("mid_rst_aw_ready", 64'(axi_aw_ready), 64'd1);
        chk("mid_rst_b_valid", 64'(axi_b_valid), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_b_valid", 64'(axi_b_valid), 64'd0);
        do_read(64'h8000_0300, 8'd3, BURST_INCR, 4'h0, 16'hFFFF);
        chk("mid_rst_d0", rd_data[0], 64'hA0);
        chk("mid_rst_d1", rd_data[1], 64'hA1);
        chk("mid_rst_d2", rd_data[2], 64'hF2);
        chk("mid_rst_d3", rd_data[3], 64'hF3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
